// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller: the phase codes are
// also decoded by the phase timer, so the numeric values are fixed.
package wm_pkg;

  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_LOCK  = 3'd1;
  localparam logic [2:0] STATE_FILL  = 3'd2;
  localparam logic [2:0] STATE_HEAT  = 3'd3;
  localparam logic [2:0] STATE_WASH  = 3'd4;
  localparam logic [2:0] STATE_RINSE = 3'd5;
  localparam logic [2:0] STATE_SPIN  = 3'd6;
  localparam logic [2:0] STATE_FAULT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = STATE_IDLE,
    S_LOCK  = STATE_LOCK,
    S_FILL  = STATE_FILL,
    S_HEAT  = STATE_HEAT,
    S_WASH  = STATE_WASH,
    S_RINSE = STATE_RINSE,
    S_SPIN  = STATE_SPIN,
    S_FAULT = STATE_FAULT
  } wm_state_e;

  // Phases that the timer measures; entry to any of these restarts the timer.
  function automatic logic is_timed(wm_state_e s);
    return (s == S_FILL) || (s == S_HEAT) || (s == S_WASH) ||
           (s == S_RINSE) || (s == S_SPIN);
  endfunction

  // Phases of a running cycle (door locked, watchdog armed).
  function automatic logic is_active(wm_state_e s);
    return (s != S_IDLE) && (s != S_FAULT);
  endfunction

endpackage

// File: rtl/wm_phase_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last phase change and
// flags expiry once the count sits at PHASE_TIMEOUT-1.
module wm_phase_watchdog #(
  parameter int PHASE_TIMEOUT = 16,
  parameter int TO_W          = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Clear wins over count so a phase change always restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == TO_W'(PHASE_TIMEOUT - 1));

endmodule

// File: rtl/wm_cycle_controller.sv
// Wash-cycle sequencer: drives the phase code to the timer, advances on the
// timer flags and handles pause, cancel, door-open and watchdog faults.
module wm_cycle_controller
  import wm_pkg::*;
#(
  parameter int RINSE_CYCLES  = 2,
  parameter int PHASE_TIMEOUT = 16,
  parameter int TO_W          = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       door_closed,
  input  logic       hot_wash,
  input  logic       pause,
  input  logic       cancel,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Completed,
  output logic [2:0] state,
  output logic       timer_clear,
  output logic       door_lock,
  output logic       water_valve,
  output logic       heater,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       drain_pump,
  output logic       done,
  output logic       fault
);

  localparam logic [1:0] RINSE_LAST = 2'(RINSE_CYCLES - 1);

  wm_state_e  state_q, state_d;
  logic       hot_q, first_fill_q, done_q, door_q, tclr_q;
  logic [1:0] rinse_cnt_q;
  logic       wd_expire, door_fall, exit_go;
  wm_state_e  exit_nxt;

  assign door_fall = door_q && !door_closed;

  wm_phase_watchdog #(.PHASE_TIMEOUT(PHASE_TIMEOUT), .TO_W(TO_W)) u_wd (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr_i    (state_d != state_q),
    .en_i     (is_active(state_q) && !pause),
    .expire_o (wd_expire)
  );

  // Exit condition of the current phase; flags are ignored in the clear cycle.
  always_comb begin
    exit_go  = 1'b0;
    exit_nxt = state_q;
    case (state_q)
      S_LOCK: begin
        exit_go  = door_closed;
        exit_nxt = S_FILL;
      end
      S_FILL: begin
        exit_go  = sig_Full && !tclr_q;
        exit_nxt = !first_fill_q ? S_RINSE : (hot_q ? S_HEAT : S_WASH);
      end
      S_HEAT: begin
        exit_go  = sig_Temperature && !tclr_q;
        exit_nxt = S_WASH;
      end
      S_WASH: begin
        exit_go  = sig_Completed && !tclr_q;
        exit_nxt = S_FILL;
      end
      S_RINSE: begin
        exit_go  = sig_Completed && !tclr_q;
        exit_nxt = (rinse_cnt_q < RINSE_LAST) ? S_FILL : S_SPIN;
      end
      S_SPIN: begin
        exit_go  = sig_Completed && !tclr_q;
        exit_nxt = S_IDLE;
      end
      default: ;
    endcase
  end

  // Next state: cancel, then pause, then door/flag/watchdog; exit beats timeout.
  always_comb begin
    state_d = state_q;
    if (cancel && (state_q == S_LOCK || state_q == S_FAULT)) begin
      state_d = S_IDLE;
    end else if (cancel && is_timed(state_q) && state_q != S_SPIN) begin
      state_d = S_SPIN;
    end else if (pause && is_active(state_q)) begin
      state_d = state_q;
    end else if (state_q == S_IDLE) begin
      if (start && !pause) state_d = S_LOCK;
    end else if (is_active(state_q)) begin
      if (door_fall && is_timed(state_q)) state_d = S_FAULT;
      else if (exit_go)                   state_d = exit_nxt;
      else if (wd_expire)                 state_d = S_FAULT;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Cycle bookkeeping: latched options, fill/rinse tracking, done, clear pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hot_q        <= 1'b0;
      first_fill_q <= 1'b1;
      rinse_cnt_q  <= '0;
      done_q       <= 1'b0;
      door_q       <= 1'b0;
      tclr_q       <= 1'b0;
    end else begin
      door_q <= door_closed;
      tclr_q <= (state_d != state_q) && is_timed(state_d);
      if (state_q == S_IDLE && state_d == S_LOCK) begin
        hot_q        <= hot_wash;
        done_q       <= 1'b0;
        first_fill_q <= 1'b1;
        rinse_cnt_q  <= '0;
      end
      if (state_q == S_FILL && state_d != S_FILL) first_fill_q <= 1'b0;
      if (state_q == S_RINSE && state_d == S_FILL) rinse_cnt_q <= rinse_cnt_q + 2'd1;
      if (state_q == S_SPIN && state_d == S_IDLE) done_q <= 1'b1;
    end
  end

  // Output decode; pause drops the actuators but keeps the door locked.
  always_comb begin
    state       = state_q;
    timer_clear = tclr_q;
    door_lock   = is_active(state_q);
    water_valve = !pause && (state_q == S_FILL);
    heater      = !pause && (state_q == S_HEAT);
    motor_on    = !pause && (state_q == S_WASH || state_q == S_RINSE || state_q == S_SPIN);
    motor_fast  = !pause && (state_q == S_SPIN);
    drain_pump  = !pause && (state_q == S_SPIN);
    done        = done_q;
    fault       = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Directed bench for the wash-cycle sequencer (default parameters).
module tb_wm_cycle_controller;

  logic       clock = 1'b0;
  logic       reset_n, start, door_closed, hot_wash, pause, cancel;
  logic       sig_Full, sig_Temperature, sig_Completed;
  logic [2:0] state;
  logic       timer_clear, door_lock, water_valve, heater, motor_on;
  logic       motor_fast, drain_pump, done, fault;

  int checks = 0;
  int errors = 0;

  // Monitor state: transitions, clear pulses, heater activity.
  logic        mon_clr;
  logic [29:0] seq;
  int          seq_n, tc_cnt;
  logic        heater_seen, saw3;
  logic [2:0]  last_st;

  wm_cycle_controller dut (
    .clock(clock), .reset_n(reset_n), .start(start), .door_closed(door_closed),
    .hot_wash(hot_wash), .pause(pause), .cancel(cancel), .sig_Full(sig_Full),
    .sig_Temperature(sig_Temperature), .sig_Completed(sig_Completed),
    .state(state), .timer_clear(timer_clear), .door_lock(door_lock),
    .water_valve(water_valve), .heater(heater), .motor_on(motor_on),
    .motor_fast(motor_fast), .drain_pump(drain_pump), .done(done), .fault(fault)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mon_clr) begin
      seq = '0; seq_n = 0; tc_cnt = 0; heater_seen = 1'b0; saw3 = 1'b0;
      last_st = state;
    end else begin
      if (timer_clear) tc_cnt++;
      if (heater) heater_seen = 1'b1;
      if (state != last_st) begin
        seq = {seq[26:0], state};
        seq_n++;
        if (state == 3'd3) saw3 = 1'b1;
        last_st = state;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  // Wait until 3 cycles after phase entry, pulse one flag, check new state.
  task automatic phase(input int which, input logic [2:0] exp, input string tag);
    tick(); tick();
    case (which)
      0: sig_Full = 1'b1;
      1: sig_Temperature = 1'b1;
      default: sig_Completed = 1'b1;
    endcase
    tick();
    sig_Full = 1'b0; sig_Temperature = 1'b0; sig_Completed = 1'b0;
    chk(tag, 32'(state), 32'(exp));
  endtask

  task automatic begin_cycle(input logic hot);
    hot_wash = hot; start = 1'b1;
    tick();
    start = 1'b0;
    chk("enter_lock", 32'(state), 32'd1);
    chk("lock_door", 32'(door_lock), 32'd1);
    tick();
    chk("enter_fill", 32'(state), 32'd2);
    chk("fill_clear", 32'(timer_clear), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; door_closed = 1'b0; hot_wash = 1'b0;
    pause = 1'b0; cancel = 1'b0; sig_Full = 1'b0; sig_Temperature = 1'b0;
    sig_Completed = 1'b0; mon_clr = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({timer_clear, door_lock, water_valve, heater, motor_on,
                         motor_fast, drain_pump, done, fault}), 32'd0);
    reset_n = 1'b1;
    tick();
    clr_mon();

    // Start held off by pause in IDLE.
    door_closed = 1'b1; start = 1'b1; pause = 1'b1;
    tick();
    chk("idle_pause", 32'(state), 32'd0);
    pause = 1'b0; start = 1'b0;

    // Hot wash, two rinses.
    begin_cycle(1'b1);
    chk("fill_valve", 32'(water_valve), 32'd1);
    phase(0, 3'd3, "hot_heat");
    chk("heater_on", 32'(heater), 32'd1);
    phase(1, 3'd4, "hot_wash");
    phase(2, 3'd2, "hot_refill1");
    phase(0, 3'd5, "hot_rinse1");
    phase(2, 3'd2, "hot_refill2");
    phase(0, 3'd5, "hot_rinse2");
    phase(2, 3'd6, "hot_spin");
    chk("spin_acts", 32'({motor_on, motor_fast, drain_pump}), 32'd7);
    phase(2, 3'd0, "hot_idle");
    chk("hot_done", 32'(done), 32'd1);
    tick();
    chk("hot_seq_n", 32'(seq_n), 32'd10);
    chk("hot_seq", 32'(seq), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd5, 3'd2, 3'd5, 3'd6, 3'd0}));
    chk("hot_tclr", 32'(tc_cnt), 32'd8);

    // Cold wash with a pause in WASH.
    clr_mon();
    begin_cycle(1'b0);
    chk("cold_done_clr", 32'(done), 32'd0);
    phase(0, 3'd4, "cold_wash");
    tick();
    pause = 1'b1;
    tick();
    chk("pause_motor", 32'(motor_on), 32'd0);
    sig_Completed = 1'b1;
    tick();
    sig_Completed = 1'b0;
    tick(); tick(); tick();
    chk("pause_state", 32'(state), 32'd4);
    chk("pause_lock", 32'({door_lock, motor_on}), 32'b10);
    pause = 1'b0;
    #1;
    chk("resume_motor", 32'({motor_on, timer_clear}), 32'b10);
    phase(2, 3'd2, "resume_fill");
    chk("refill_clear", 32'(timer_clear), 32'd1);
    phase(0, 3'd5, "cold_rinse1");
    phase(2, 3'd2, "cold_refill2");
    phase(0, 3'd5, "cold_rinse2");
    phase(2, 3'd6, "cold_spin");
    phase(2, 3'd0, "cold_idle");
    tick();
    chk("cold_no_heat", 32'({heater_seen, saw3}), 32'd0);
    chk("cold_done", 32'(done), 32'd1);

    // Watchdog: sig_Full withheld.
    begin_cycle(1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("wd_pre", 32'(state), 32'd2);
    tick();
    chk("wd_fault", 32'(state), 32'd7);
    chk("wd_outs", 32'({fault, door_lock, water_valve}), 32'b100);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("wd_cancel", 32'({state, fault}), 32'd0);

    // Cancel in HEAT_WATER.
    begin_cycle(1'b1);
    phase(0, 3'd3, "cx_heat");
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cx_spin", 32'(state), 32'd6);
    chk("cx_outs", 32'({timer_clear, drain_pump}), 32'b11);
    phase(2, 3'd0, "cx_idle");
    chk("cx_done", 32'(done), 32'd1);

    // Door opened in RINSE.
    begin_cycle(1'b0);
    phase(0, 3'd4, "door_wash");
    phase(2, 3'd2, "door_fill");
    phase(0, 3'd5, "door_rinse");
    tick();
    door_closed = 1'b0;
    tick();
    chk("door_fault", 32'({state, fault}), 32'({3'd7, 1'b1}));
    cancel = 1'b1; door_closed = 1'b1;
    tick();
    cancel = 1'b0;
    chk("door_cancel", 32'(state), 32'd0);

    // Asynchronous reset mid-SPIN.
    begin_cycle(1'b0);
    phase(0, 3'd4, "rs_wash");
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("rs_spin", 32'(state), 32'd6);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rs_state", 32'(state), 32'd0);
    chk("rs_outs", 32'({timer_clear, door_lock, water_valve, heater, motor_on,
                        motor_fast, drain_pump, done, fault}), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
